// File: rtl/ncca_seq_mul8_ctrl_if.sv
// ----------------------------------------------------------------------------
// ncca_seq_mul8_ctrl_if
// Bundles every handshake and data signal of the sequenced 8x8 multiplier:
//   in_valid/in_ready/a/b     operand pair from upstream
//   sub_a/sub_b/sub_mode/
//   sub_valid/sub_prod        shared external combinational sub-multiplier
//   out_valid/out_ready/prod8 accumulated product to downstream
// Handshake rule for both in_* and out_*: a transfer happens on a rising clk
// edge where valid && ready are both 1; the sender keeps valid and its data
// stable until that edge, and ready may not depend on nothing but state.
// modport slave  : the multiplier sequencer's view.
// modport master : the environment's view (operand source, sub-multiplier,
//                  result sink).
// ----------------------------------------------------------------------------
interface ncca_seq_mul8_ctrl_if #(
  parameter int SUB_W = 4
);
  localparam int W = 2 * SUB_W;

  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic [SUB_W-1:0]   sub_a;
  logic [SUB_W-1:0]   sub_b;
  logic               sub_mode;
  logic               sub_valid;
  logic [2*SUB_W-1:0] sub_prod;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-1:0]     prod8;

  modport slave (
    input  in_valid, a, b, sub_prod, out_ready,
    output in_ready, sub_a, sub_b, sub_mode, sub_valid, out_valid, prod8
  );

  modport master (
    output in_valid, a, b, sub_prod, out_ready,
    input  in_ready, sub_a, sub_b, sub_mode, sub_valid, out_valid, prod8
  );
endinterface

// File: rtl/ncca_seq_mul8_ctrl.sv
// ----------------------------------------------------------------------------
// ncca_seq_mul8_ctrl
// Shares one external SUB_W x SUB_W combinational sub-multiplier across the
// four partial products of a W x W multiply (W = 2*SUB_W). Partial products
// are issued HH, HL, LH, LL and summed into a 2*W-bit accumulator.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        ncca_seq_mul8_ctrl_if.slave (operands, sub-multiplier, result)
//   dbg_state  current FSM state encoding (state_t)
// Parameters:
//   SUB_W      sub-multiplier operand width
//   ZERO_SKIP  1: a zero operand goes straight to DONE with product 0
// ----------------------------------------------------------------------------
module ncca_seq_mul8_ctrl #(
  parameter int SUB_W     = 4,
  parameter int ZERO_SKIP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ncca_seq_mul8_ctrl_if.slave       bus,
  output logic [2:0]                dbg_state
);
  localparam int W = 2 * SUB_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HH   = 3'd1,
    S_HL   = 3'd2,
    S_LH   = 3'd3,
    S_LL   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ra_q, ra_d;
  logic [W-1:0]   rb_q, rb_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] pp_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
    end
  end

  // Sub-product zero-extended to accumulator width before shifting.
  assign pp_ext = {{(2*W-2*SUB_W){1'b0}}, bus.sub_prod};

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ra_d  = bus.a;
          rb_d  = bus.b;
          acc_d = '0;
          if ((ZERO_SKIP != 0) && ((bus.a == '0) || (bus.b == '0)))
            state_d = S_DONE;
          else
            state_d = S_HH;
        end
      end
      S_HH: begin
        acc_d   = acc_q + (pp_ext << W);
        state_d = S_HL;
      end
      S_HL: begin
        acc_d   = acc_q + (pp_ext << SUB_W);
        state_d = S_LH;
      end
      S_LH: begin
        acc_d   = acc_q + (pp_ext << SUB_W);
        state_d = S_LL;
      end
      S_LL: begin
        acc_d   = acc_q + pp_ext;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sub-multiplier operands decode purely from state and latched operands.
  always_comb begin
    bus.sub_a     = '0;
    bus.sub_b     = '0;
    bus.sub_mode  = 1'b0;
    bus.sub_valid = 1'b0;
    case (state_q)
      S_HH: begin
        bus.sub_a     = ra_q[W-1:SUB_W];
        bus.sub_b     = rb_q[W-1:SUB_W];
        bus.sub_mode  = 1'b1;
        bus.sub_valid = 1'b1;
      end
      S_HL: begin
        bus.sub_a     = ra_q[W-1:SUB_W];
        bus.sub_b     = rb_q[SUB_W-1:0];
        bus.sub_valid = 1'b1;
      end
      S_LH: begin
        bus.sub_a     = ra_q[SUB_W-1:0];
        bus.sub_b     = rb_q[W-1:SUB_W];
        bus.sub_valid = 1'b1;
      end
      S_LL: begin
        bus.sub_a     = ra_q[SUB_W-1:0];
        bus.sub_b     = rb_q[SUB_W-1:0];
        bus.sub_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // in_ready is forced low while reset is held even though state is IDLE.
  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.prod8     = acc_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_ncca_seq_mul8_ctrl.sv
module tb_ncca_seq_mul8_ctrl;
  logic clk;
  logic rst_n;
  logic [2:0] dbg0, dbg1;
  int n_checks;
  int n_pass;

  ncca_seq_mul8_ctrl_if #(.SUB_W(4)) bus0 ();
  ncca_seq_mul8_ctrl_if #(.SUB_W(4)) bus1 ();

  ncca_seq_mul8_ctrl #(.SUB_W(4), .ZERO_SKIP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0));
  ncca_seq_mul8_ctrl #(.SUB_W(4), .ZERO_SKIP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1));

  // Exact 4x4 sub-multiplier model
  assign bus0.sub_prod = bus0.sub_a * bus0.sub_b;
  assign bus1.sub_prod = bus1.sub_a * bus1.sub_b;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send0(input logic [7:0] a, input logic [7:0] b,
                       input int max_cyc, output bit ok);
    bus0.a = a; bus0.b = b; bus0.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (bus0.in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus0.in_valid = 1'b0;
  endtask

  // Waits for out_valid; lat = negedges after the accept edge.
  task automatic wait_out0(input int max_cyc, output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (bus0.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus0.in_ready !== 1'b0) $display("FAIL rst_in_ready_low got %b exp 0", bus0.in_ready);
    else n_pass++;
    n_checks++;
    if ({bus0.out_valid, bus0.sub_valid, bus0.prod8} !== 17'h0)
      $display("FAIL rst_outputs got ov=%b sv=%b p=%h exp 0", bus0.out_valid, bus0.sub_valid, bus0.prod8);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus0.in_ready !== 1'b1 || dbg0 !== 3'd0)
      $display("FAIL rst_idle got rdy=%b st=%0d exp rdy=1 st=0", bus0.in_ready, dbg0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    logic       em [4];
    bit ok; int lat;
    ea = '{4'h1, 4'h1, 4'h2, 4'h2};
    eb = '{4'h3, 4'h4, 4'h3, 4'h4};
    em = '{1'b1, 1'b0, 1'b0, 1'b0};
    bus0.out_ready = 1'b0;
    send0(8'h12, 8'h34, 5, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_accept got timeout exp accept");
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if ({bus0.sub_valid, bus0.sub_a, bus0.sub_b, bus0.sub_mode, bus0.out_valid} !==
          {1'b1, ea[k], eb[k], em[k], 1'b0})
        $display("FAIL basic_step%0d got v=%b a=%h b=%h m=%b ov=%b exp v=1 a=%h b=%h m=%b ov=0",
                 k, bus0.sub_valid, bus0.sub_a, bus0.sub_b, bus0.sub_mode, bus0.out_valid,
                 ea[k], eb[k], em[k]);
      else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (bus0.out_valid !== 1'b1 || bus0.prod8 !== 16'h03A8 || bus0.sub_valid !== 1'b0)
      $display("FAIL basic_result got ov=%b p=%h sv=%b exp ov=1 p=03a8 sv=0",
               bus0.out_valid, bus0.prod8, bus0.sub_valid);
    else n_pass++;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
    #1;
    n_checks++;
    if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1)
      $display("FAIL basic_release got ov=%b rdy=%b exp ov=0 rdy=1", bus0.out_valid, bus0.in_ready);
    else n_pass++;
    @(negedge clk);
    lat = 0;
  endtask

  task automatic test_max();
    bit ok; int lat;
    bus0.out_ready = 1'b1;
    send0(8'hFF, 8'hFF, 5, ok);
    wait_out0(10, lat, ok);
    n_checks++;
    if (!ok || lat != 4 || bus0.prod8 !== 16'hFE01)
      $display("FAIL max_result got ok=%b lat=%0d p=%h exp ok=1 lat=4 p=fe01", ok, lat, bus0.prod8);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0)
      $display("FAIL max_ready_back got rdy=%b ov=%b exp rdy=1 ov=0", bus0.in_ready, bus0.out_valid);
    else n_pass++;
    bus0.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_skip();
    bit ok; int lat; int nsub;
    send0(8'h00, 8'h9C, 5, ok);
    #1;
    n_checks++;
    if (!ok || bus0.out_valid !== 1'b1 || bus0.prod8 !== 16'h0 || bus0.sub_valid !== 1'b0)
      $display("FAIL skip_result got ok=%b ov=%b p=%h sv=%b exp ok=1 ov=1 p=0 sv=0",
               ok, bus0.out_valid, bus0.prod8, bus0.sub_valid);
    else n_pass++;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
    // same stimulus on the ZERO_SKIP=0 instance
    bus1.a = 8'h00; bus1.b = 8'h9C; bus1.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus1.in_ready !== 1'b1) $display("FAIL noskip_ready got %b exp 1", bus1.in_ready);
    else n_pass++;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    nsub = 0; ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus1.out_valid) begin ok = 1'b1; break; end
      if (bus1.sub_valid) nsub++;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || nsub != 4 || bus1.prod8 !== 16'h0)
      $display("FAIL noskip_result got ok=%b steps=%0d p=%h exp ok=1 steps=4 p=0", ok, nsub, bus1.prod8);
    else n_pass++;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok; int lat; int bad;
    bus0.out_ready = 1'b0;
    send0(8'h0F, 8'hF0, 5, ok);
    wait_out0(10, lat, ok);
    n_checks++;
    if (!ok || bus0.prod8 !== 16'h0E10)
      $display("FAIL stall_result got ok=%b p=%h exp ok=1 p=0e10", ok, bus0.prod8);
    else n_pass++;
    // new operands offered while the result is held
    bus0.a = 8'h02; bus0.b = 8'h03; bus0.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus0.out_valid !== 1'b1 || bus0.prod8 !== 16'h0E10 || bus0.in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL stall_hold got %0d bad cycles exp 0", bad);
    else n_pass++;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
    send0(8'h02, 8'h03, 5, ok);
    wait_out0(10, lat, ok);
    n_checks++;
    if (!ok || bus0.prod8 !== 16'h0006)
      $display("FAIL stall_next got ok=%b p=%h exp ok=1 p=0006", ok, bus0.prod8);
    else n_pass++;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok; int lat;
    send0(8'hAB, 8'hCD, 5, ok);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus0.sub_valid !== 1'b1 || bus0.sub_mode !== 1'b0 || bus0.sub_a !== 4'hA || bus0.sub_b !== 4'hD)
      $display("FAIL abort_in_hl got v=%b m=%b a=%h b=%h exp v=1 m=0 a=a b=d",
               bus0.sub_valid, bus0.sub_mode, bus0.sub_a, bus0.sub_b);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus0.in_ready, bus0.out_valid, bus0.sub_valid, bus0.sub_mode, bus0.sub_a, bus0.sub_b, bus0.prod8} !== 28'h0)
      $display("FAIL abort_outputs got rdy=%b ov=%b sv=%b m=%b a=%h b=%h p=%h exp all 0",
               bus0.in_ready, bus0.out_valid, bus0.sub_valid, bus0.sub_mode, bus0.sub_a, bus0.sub_b, bus0.prod8);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send0(8'h03, 8'h05, 5, ok);
    wait_out0(10, lat, ok);
    n_checks++;
    if (!ok || bus0.prod8 !== 16'h000F)
      $display("FAIL abort_next got ok=%b p=%h exp ok=1 p=000f", ok, bus0.prod8);
    else n_pass++;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [7:0] ra, rb;
    logic [15:0] e;
    bit ok; bit done;
    for (int n = 0; n < 100; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send0(ra, rb, 10, ok);
      n_checks++;
      if (!ok) $display("FAIL rand_accept%0d got timeout exp accept", n);
      else begin
        n_pass++;
        exp_q.push_back(16'(ra * rb));
      end
      done = 1'b0;
      for (int i = 0; i < 40 && ok; i++) begin
        bus0.out_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus0.out_valid && bus0.out_ready) begin
          e = exp_q.pop_front();
          n_checks++;
          if (bus0.prod8 !== e)
            $display("FAIL rand_prod%0d got %h exp %h (a=%h b=%h)", n, bus0.prod8, e, ra, rb);
          else n_pass++;
          done = 1'b1;
        end
        @(negedge clk);
        if (done) break;
      end
      bus0.out_ready = 1'b0;
      n_checks++;
      if (ok && !done) $display("FAIL rand_out%0d got timeout exp out_valid", n);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rand_leftover got %0d exp 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_zero_skip();
    test_stall();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
